barrier_initiator: RTL

//  Per-core bus initiator that drives the hardware barrier unit over a peripheral-bus master port.

---
 rtl/barrier_initiator.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/barrier_initiator.sv
// Per-core bus initiator for the hardware barrier unit: sequences the register accesses of one
// command at a time, then waits for the barrier event (with optional timeout) and responds.
module barrier_initiator #(
    parameter int unsigned           NB_CORES     = 4,
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BARRIER_BASE = '0,
    parameter int unsigned           CORE_ID      = 0,
    parameter int unsigned           TIMEOUT_W    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [NB_CORES-1:0]   cmd_trig_mask_i,
    input  logic [NB_CORES-1:0]   cmd_targ_mask_i,
    input  logic [TIMEOUT_W-1:0]  timeout_cycles_i,
    input  logic                  barrier_event_i,
    output logic                  rsp_valid_o,
    output logic [NB_CORES-1:0]   rsp_data_o,
    output logic                  rsp_timeout_o,
    output logic                  bus_req_o,
    output logic [ADDR_WIDTH-1:0] bus_add_o,
    output logic                  bus_we_n_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    output logic [3:0]            bus_be_o,
    output logic [4:0]            bus_id_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_r_valid_i,
    input  logic [DATA_WIDTH-1:0] bus_r_rdata_i
);

    localparam logic [1:0] OpConfig     = 2'b00;
    localparam logic [1:0] OpArrive     = 2'b01;
    localparam logic [1:0] OpArriveWait = 2'b10;
    localparam logic [1:0] OpReadStatus = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] AddrTrigMask = BARRIER_BASE + ADDR_WIDTH'(32'h00);
    localparam logic [ADDR_WIDTH-1:0] AddrStatus   = BARRIER_BASE + ADDR_WIDTH'(32'h04);
    localparam logic [ADDR_WIDTH-1:0] AddrTargMask = BARRIER_BASE + ADDR_WIDTH'(32'h0C);
    localparam logic [ADDR_WIDTH-1:0] AddrTrigger  = BARRIER_BASE + ADDR_WIDTH'(32'h10);

    typedef enum logic [2:0] {
        StIdle, StWrTrig, StWrTarg, StWrArrive, StRdStat, StWaitRsp, StWaitEvt, StDone
    } state_e;

    state_e                state_q;
    logic [1:0]            op_q;
    logic [NB_CORES-1:0]   targ_q;
    logic [TIMEOUT_W-1:0]  timeout_q;
    logic [TIMEOUT_W-1:0]  cnt_q;
    logic                  evt_seen_q;
    logic                  cfg_second_q;

    // Only the low NB_CORES bits of read data carry status.
    logic unused_rdata;
    assign unused_rdata = ^bus_r_rdata_i;

    assign bus_be_o = 4'hF;
    assign bus_id_o = 5'(CORE_ID);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            op_q          <= OpConfig;
            targ_q        <= '0;
            timeout_q     <= '0;
            cnt_q         <= '0;
            evt_seen_q    <= 1'b0;
            cfg_second_q  <= 1'b0;
            cmd_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_data_o    <= '0;
            rsp_timeout_o <= 1'b0;
            bus_req_o     <= 1'b0;
            bus_add_o     <= '0;
            bus_we_n_o    <= 1'b1;
            bus_wdata_o   <= '0;
        end else begin
            // Catch events that race ahead of the arrive write so none is lost.
            if (op_q == OpArriveWait && state_q != StIdle && state_q != StDone && barrier_event_i) begin
                evt_seen_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        op_q          <= cmd_op_i;
                        targ_q        <= cmd_targ_mask_i;
                        timeout_q     <= timeout_cycles_i;
                        evt_seen_q    <= 1'b0;
                        cfg_second_q  <= 1'b0;
                        cmd_ready_o   <= 1'b0;
                        rsp_data_o    <= '0;
                        rsp_timeout_o <= 1'b0;
                        bus_req_o     <= 1'b1;
                        unique case (cmd_op_i)
                            OpConfig: begin
                                state_q     <= StWrTrig;
                                bus_add_o   <= AddrTrigMask;
                                bus_we_n_o  <= 1'b0;
                                bus_wdata_o <= DATA_WIDTH'(cmd_trig_mask_i);
                            end
                            OpArrive, OpArriveWait: begin
                                state_q     <= StWrArrive;
                                bus_add_o   <= AddrTrigger;
                                bus_we_n_o  <= 1'b0;
                                bus_wdata_o <= DATA_WIDTH'(1) << CORE_ID;
                            end
                            OpReadStatus: begin
                                state_q     <= StRdStat;
                                bus_add_o   <= AddrStatus;
                                bus_we_n_o  <= 1'b1;
                                bus_wdata_o <= '0;
                            end
                        endcase
                    end
                end

                StWrTrig, StWrTarg, StWrArrive, StRdStat: begin
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        state_q   <= StWaitRsp;
                    end
                end

                StWaitRsp: begin
                    if (bus_r_valid_i) begin
                        unique case (op_q)
                            OpConfig: begin
                                if (!cfg_second_q) begin
                                    cfg_second_q <= 1'b1;
                                    state_q      <= StWrTarg;
                                    bus_req_o    <= 1'b1;
                                    bus_add_o    <= AddrTargMask;
                                    bus_we_n_o   <= 1'b0;
                                    bus_wdata_o  <= DATA_WIDTH'(targ_q);
                                end else begin
                                    state_q     <= StDone;
                                    rsp_valid_o <= 1'b1;
                                end
                            end
                            OpArrive: begin
                                state_q     <= StDone;
                                rsp_valid_o <= 1'b1;
                            end
                            OpArriveWait: begin
                                state_q <= StWaitEvt;
                                cnt_q   <= '0;
                            end
                            OpReadStatus: begin
                                state_q     <= StDone;
                                rsp_valid_o <= 1'b1;
                                rsp_data_o  <= bus_r_rdata_i[NB_CORES-1:0];
                            end
                        endcase
                    end
                end

                StWaitEvt: begin
                    cnt_q <= cnt_q + TIMEOUT_W'(1);
                    // An event arriving on the expiry cycle takes priority over the timeout.
                    if (evt_seen_q || barrier_event_i) begin
                        state_q     <= StDone;
                        rsp_valid_o <= 1'b1;
                    end else if (timeout_q != '0 && cnt_q == timeout_q - TIMEOUT_W'(1)) begin
                        state_q       <= StDone;
                        rsp_valid_o   <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                    end
                end

                StDone: begin
                    rsp_valid_o <= 1'b0;
                    cmd_ready_o <= 1'b1;
                    state_q     <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
